// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: datapath widths, the hardwired-zero register
// index and the write-back bundle consumed by the EX-stage forwarding unit.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wb_bundle_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: one commit port, two combinational read ports
// with write-through bypass, and register 0 hardwired to zero.
module regfile_2r1w
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREG   = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem_q [NREG];
    logic              commit_s;

    assign commit_s = we && (waddr != ZERO_ADDR);

    // Array storage: cleared asynchronously, written from the pre-edge WB bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (commit_s) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port 1: r0 rule first, so a pending write to r0 can never leak out.
    always_comb begin
        rdata1 = {DATA_W{1'b0}};
        if (raddr1 == ZERO_ADDR) begin
            rdata1 = {DATA_W{1'b0}};
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = mem_q[raddr1];
        end
    end

    // Read port 2: identical priority to port 1, fully independent.
    always_comb begin
        rdata2 = {DATA_W{1'b0}};
        if (raddr2 == ZERO_ADDR) begin
            rdata2 = {DATA_W{1'b0}};
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = mem_q[raddr2];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB pipeline register with flush-over-advance priority,
// feeding the register file commit port and exported for EX forwarding.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREG   = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              flush,
    input  logic              in_reg_write,
    input  logic [ADDR_W-1:0] in_waddr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata
);

    logic              wb_valid_d, wb_valid_q;
    logic [ADDR_W-1:0] wb_waddr_d, wb_waddr_q;
    logic [DATA_W-1:0] wb_wdata_d, wb_wdata_q;

    // Next WB bundle: a squashed slot is fully zeroed, a stall holds everything.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_waddr_d = wb_waddr_q;
        wb_wdata_d = wb_wdata_q;
        if (flush) begin
            wb_valid_d = 1'b0;
            wb_waddr_d = {ADDR_W{1'b0}};
            wb_wdata_d = {DATA_W{1'b0}};
        end else if (advance) begin
            wb_valid_d = in_reg_write;
            wb_waddr_d = in_waddr;
            wb_wdata_d = in_wdata;
        end else begin
            wb_valid_d = wb_valid_q;
            wb_waddr_d = wb_waddr_q;
            wb_wdata_d = wb_wdata_q;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_waddr_q <= {ADDR_W{1'b0}};
            wb_wdata_q <= {DATA_W{1'b0}};
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_waddr = wb_waddr_q;
    assign wb_wdata = wb_wdata_q;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_valid_q),
        .waddr  (wb_waddr_q),
        .wdata  (wb_wdata_q),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile: reset, bypass/commit latency, r0 rule,
// stall/flush priority, back-to-back writes and asynchronous reset.
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        advance;
    logic        flush;
    logic        in_reg_write;
    logic [4:0]  in_waddr;
    logic [31:0] in_wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        wb_valid;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    wb_regfile dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .advance      (advance),
        .flush        (flush),
        .in_reg_write (in_reg_write),
        .in_waddr     (in_waddr),
        .in_wdata     (in_wdata),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .wb_valid     (wb_valid),
        .wb_waddr     (wb_waddr),
        .wb_wdata     (wb_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One active edge, then settle inputs/outputs away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d);
        in_reg_write = we;
        in_waddr     = a;
        in_wdata     = d;
    endtask

    initial begin
        rst_n   = 1'b0;
        advance = 1'b0;
        flush   = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        raddr1  = 5'd5;
        raddr2  = 5'd31;
        #12;
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_rdata2", rdata2, 32'h0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_waddr", {27'd0, wb_waddr}, 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic write: bypass in cycle 1, array from cycle 2
        advance = 1'b1;
        drive(1'b1, 5'd7, 32'hDEADBEEF);
        raddr1 = 5'd7;
        tick();
        chk("wr_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("wr_wb_waddr", {27'd0, wb_waddr}, 32'd7);
        chk("wr_wb_wdata", wb_wdata, 32'hDEADBEEF);
        chk("wr_bypass", rdata1, 32'hDEADBEEF);
        drive(1'b0, 5'd0, 32'h0);
        tick();
        chk("wr_idle_valid", {31'd0, wb_valid}, 32'd0);
        chk("wr_array", rdata1, 32'hDEADBEEF);
        tick();
        chk("wr_array2", rdata1, 32'hDEADBEEF);

        // r0 protection
        drive(1'b1, 5'd0, 32'h12345678);
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        tick();
        chk("r0_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("r0_cyc1_p1", rdata1, 32'h0);
        chk("r0_cyc1_p2", rdata2, 32'h0);
        drive(1'b0, 5'd0, 32'h0);
        tick();
        chk("r0_cyc2", rdata1, 32'h0);
        tick();
        chk("r0_cyc3", rdata1, 32'h0);

        // Stall and flush
        drive(1'b1, 5'd3, 32'hA5A5A5A5);
        raddr1 = 5'd3;
        raddr2 = 5'd4;
        tick();
        chk("sf_load_addr", {27'd0, wb_waddr}, 32'd3);
        chk("sf_bypass", rdata1, 32'hA5A5A5A5);
        advance = 1'b0;
        drive(1'b1, 5'd4, 32'h1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("sf_stall_addr", {27'd0, wb_waddr}, 32'd3);
            chk("sf_stall_valid", {31'd0, wb_valid}, 32'd1);
            chk("sf_stall_data", wb_wdata, 32'hA5A5A5A5);
            chk("sf_stall_r3", rdata1, 32'hA5A5A5A5);
            chk("sf_stall_r4", rdata2, 32'h0);
        end
        flush   = 1'b1;
        advance = 1'b1;
        tick();
        chk("sf_flush_valid", {31'd0, wb_valid}, 32'd0);
        chk("sf_flush_addr", {27'd0, wb_waddr}, 32'd0);
        chk("sf_flush_data", wb_wdata, 32'h0);
        chk("sf_commit_r3", rdata1, 32'hA5A5A5A5);
        chk("sf_flush_r4", rdata2, 32'h0);
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        tick();
        chk("sf_after_r3", rdata1, 32'hA5A5A5A5);
        chk("sf_after_r4", rdata2, 32'h0);

        // Back-to-back writes to the same register, both ports on it
        raddr1 = 5'd9;
        raddr2 = 5'd9;
        drive(1'b1, 5'd9, 32'h11);
        tick();
        chk("b2b_p1_0x11", rdata1, 32'h11);
        chk("b2b_p2_0x11", rdata2, 32'h11);
        drive(1'b1, 5'd9, 32'h22);
        tick();
        chk("b2b_p1_0x22", rdata1, 32'h22);
        chk("b2b_p2_0x22", rdata2, 32'h22);
        drive(1'b0, 5'd0, 32'h0);
        tick();
        chk("b2b_valid", {31'd0, wb_valid}, 32'd0);
        chk("b2b_p1_arr", rdata1, 32'h22);
        chk("b2b_p2_arr", rdata2, 32'h22);

        // Different addresses on the two ports, one bypass, one array
        drive(1'b1, 5'd12, 32'hCAFEF00D);
        raddr1 = 5'd12;
        raddr2 = 5'd7;
        tick();
        chk("mix_bypass", rdata1, 32'hCAFEF00D);
        chk("mix_array", rdata2, 32'hDEADBEEF);

        // Async reset mid-stream with a live, uncommitted bundle
        drive(1'b1, 5'd10, 32'hFF);
        raddr1 = 5'd10;
        tick();
        chk("ar_pre_valid", {31'd0, wb_valid}, 32'd1);
        chk("ar_pre_bypass", rdata1, 32'hFF);
        advance = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, wb_valid}, 32'd0);
        chk("ar_waddr", {27'd0, wb_waddr}, 32'd0);
        chk("ar_wdata", wb_wdata, 32'h0);
        chk("ar_r10", rdata1, 32'h0);
        chk("ar_r7_cleared", rdata2, 32'h0);
        raddr2 = 5'd9;
        #1;
        chk("ar_r9_cleared", rdata2, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("ar_post_r10", rdata1, 32'h0);
        chk("ar_post_valid", {31'd0, wb_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus architectural register file for the 5-stage CPU.
- Sits directly downstream of the destination-register select mux (rt/rd → 5-bit write address).
- Registers the MEM/WB bundle (reg_write, write address, write data) and commits it to a 32×32 register file.
- Provides two combinational read ports with write-through bypass. Exports the WB bundle for EX-stage forwarding.

Parameters:
- DATA_W, 32, register/data width.
- ADDR_W, 5, register address width.
- NREG, 32, number of registers (must equal 2**ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- advance  in  1  pipeline enable; 0 = stall, WB register holds.
- flush  in  1  squash the incoming bundle; has priority over advance.
- in_reg_write  in  1  MEM-stage register-write enable.
- in_waddr  in  ADDR_W  destination address from the dest-select mux.
- in_wdata  in  DATA_W  MEM-stage result (ALU or load data).
- raddr1  in  ADDR_W  read port 1 address (ID stage).
- raddr2  in  ADDR_W  read port 2 address (ID stage).
- rdata1  out  DATA_W  read port 1 data, combinational.
- rdata2  out  DATA_W  read port 2 data, combinational.
- wb_valid  out  1  WB register holds a live write.
- wb_waddr  out  ADDR_W  WB register write address.
- wb_wdata  out  DATA_W  WB register write data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous):
  - wb_valid=0, wb_waddr=0, wb_wdata=0.
  - All NREG array entries = 0.
  - rdata1/rdata2 therefore read 0.
- WB register update at posedge clk, in priority order:
  - flush=1 → wb_valid<=0; wb_waddr/wb_wdata are don't-care, implementation clears them to 0.
  - else advance=1 → wb_valid<=in_reg_write, wb_waddr<=in_waddr, wb_wdata<=in_wdata.
  - else → hold all three.
- Latency: a bundle presented in cycle N appears on wb_* in cycle N+1 and is in the array from cycle N+2.
- Array commit:
  - At every posedge where wb_valid=1 and wb_waddr!=0: array[wb_waddr]<=wb_wdata.
  - Commit uses the pre-edge WB contents. The same edge may simultaneously load a new bundle or flush.
  - Repeated commits while stalled are idempotent.
- Register 0 is hardwired:
  - Writes to address 0 are never stored.
  - A read of address 0 always returns 0, including when wb_valid=1 and wb_waddr=0.
- Read ports (each independent), for port k:
  - raddrk==0 → 0.
  - else wb_valid=1 and wb_waddr==raddrk → wb_wdata (write-through bypass).
  - else → array[raddrk].
- Both read ports may use the same address, and both may hit the bypass in the same cycle.
- Stall with a live bundle: wb_* held; bypass continues to supply the value.
- Flush while wb_valid=1: the old bundle still commits on that edge; wb_valid=0 afterwards.
- Reset mid-operation: an uncommitted WB bundle is lost and the array is zeroed immediately. No partial write occurs.
- Address width: in_waddr is used unmodified; NREG=2**ADDR_W, so no out-of-range addresses exist.

Decomposition:
- Shared package cpu_pkg: DATA_W and ADDR_W constants, the REG_ZERO=0 constant, and a wb_bundle typedef {valid, waddr, wdata}, reused by the EX forwarding unit.
- One natural sub-module, regfile_2r1w: the array, async reset, commit logic, r0 rule and bypass muxes.
- wb_regfile keeps the WB pipeline register and the flush/advance priority.

Test Plan:
- Reset and read: rst_n=0 pulse, then read raddr1=5, raddr2=31 → rdata1=0, rdata2=0, wb_valid=0.
- Basic write:
  - Cycle 0: in_reg_write=1, in_waddr=7, in_wdata=0xDEADBEEF, advance=1.
  - Cycle 1: wb_valid=1, wb_waddr=7, and raddr1=7 returns 0xDEADBEEF via bypass.
  - Cycle 2 onward, with in_reg_write=0: raddr1=7 still returns 0xDEADBEEF from the array.
- r0 protection: write 0x12345678 to address 0 → rdata1 with raddr1=0 is 0 in cycles 1 and 2 and remains 0 permanently.
- Stall and flush:
  - Load addr 3 = 0xA5A5A5A5.
  - Cycles 1-3: advance=0 while the inputs change to addr 4 = 0x1 → wb_waddr stays 3 and addr 4 reads 0.
  - Next cycle: flush=1 → wb_valid=0 and addr 3 = 0xA5A5A5A5 committed.
- Back-to-back same register: writes to addr 9 of 0x11 then 0x22 on consecutive cycles → rdata1/rdata2 (both raddr=9) show 0x11, then 0x22, then 0x22 from the array.
- Async reset mid-stream: assert rst_n=0 between edges while wb_valid=1 with addr 10 = 0xFF → wb_valid=0 and addr 10 reads 0 without waiting for a clock edge.
